// File: rtl/and_if_if.sv
// and_if_if: operand/result handshake bundle for and_if (parity only with AND_IF_PARITY_EN)
interface and_if_if #(parameter int WIDTH = 4);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
`ifdef AND_IF_PARITY_EN
    logic             parity;
    modport master (output in_valid, a, b, op, out_ready,
                    input in_ready, out_valid, y, zero, parity);
    modport slave (input in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, y, zero, parity);
`else
    modport master (output in_valid, a, b, op, out_ready,
                    input in_ready, out_valid, y, zero);
    modport slave (input in_valid, a, b, op, out_ready,
                   output in_ready, out_valid, y, zero);
`endif
endinterface

// File: rtl/and_if.sv
// and_if: registered single-entry bitwise AND/OR/XOR/NAND unit; AND_IF_PARITY_EN adds a parity output
module and_if #(
    parameter int WIDTH = 4
) (
    input logic   clk,
    input logic   rst,
    and_if_if.slave bus
);
    logic [WIDTH-1:0] res;
    logic             in_fire;
    always_comb begin
        res = bus.op == 2'd0 ? bus.a & bus.b :
              bus.op == 2'd1 ? bus.a | bus.b :
              bus.op == 2'd2 ? bus.a ^ bus.b : ~(bus.a & bus.b);
    end
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign in_fire      = bus.in_valid && bus.in_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.zero      <= 1'b1;
        end else if (in_fire) begin
            bus.out_valid <= 1'b1;
            bus.y         <= res;
            bus.zero      <= res == '0;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
`ifdef AND_IF_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)
            bus.parity <= 1'b0;
        else if (in_fire)
            bus.parity <= ^res;
    end
`endif
endmodule

// File: tb/tb_and_if.sv
// tb_and_if: vector table, handshake corner sequences and random traffic against a queue model
module tb_and_if;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    and_if_if #(.WIDTH(4)) bus ();
    and_if #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [3:0] y;
        logic       zero;
    } vec_t;
    vec_t tv[6];

    // Truth tables indexed by {a_bit, b_bit}, one nibble per op
    function automatic logic [3:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [15:0] tt;
        logic [3:0]  r;
        tt = {4'b0111, 4'b0110, 4'b1110, 4'b1000};
        for (int i = 0; i < 4; i++)
            r[i] = tt[op*4 + {a[i], b[i]}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input logic r);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.out_ready = r;
    endtask

    initial begin
        logic [3:0] q[$];
        logic [3:0] last;
        logic [3:0] ra, rb, exp_y;
        logic [1:0] rop;
        logic       rv, rr, exp_rdy;
        tv[0] = '{4'b1010, 4'b0101, 2'd0, 4'b0000, 1'b1};
        tv[1] = '{4'b1010, 4'b0101, 2'd1, 4'b1111, 1'b0};
        tv[2] = '{4'b1010, 4'b0101, 2'd2, 4'b1111, 1'b0};
        tv[3] = '{4'b1010, 4'b0101, 2'd3, 4'b1111, 1'b0};
        tv[4] = '{4'b1100, 4'b1010, 2'd2, 4'b0110, 1'b0};
        tv[5] = '{4'b1111, 4'b1111, 2'd3, 4'b0000, 1'b1};

        rst = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
        tick();
        tick();
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset y", bus.y, 0);
        chk("reset zero", bus.zero, 1);
        chk("reset in_ready", bus.in_ready, 1);
`ifdef AND_IF_PARITY_EN
        chk("reset parity", bus.parity, 0);
`endif

        rst = 1'b0;
        drive(1'b1, 4'b1010, 4'b1111, 2'd0, 1'b1);
        tick();
        chk("first y", bus.y, 4'b1010);
        chk("first zero", bus.zero, 0);
        chk("first out_valid", bus.out_valid, 1);
`ifdef AND_IF_PARITY_EN
        chk("first parity", bus.parity, 0);
`endif

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tv[i].a, tv[i].b, tv[i].op, 1'b1);
            chk($sformatf("vec%0d in_ready", i), bus.in_ready, 1);
            tick();
            chk($sformatf("vec%0d y", i), bus.y, tv[i].y);
            chk($sformatf("vec%0d zero", i), bus.zero, tv[i].zero);
            chk($sformatf("vec%0d out_valid", i), bus.out_valid, 1);
        end

        drive(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
        tick();
        chk("drain out_valid", bus.out_valid, 0);
        chk("drain y hold", bus.y, 4'b0000);

        // Backpressure: second beat must wait until out_ready
        drive(1'b1, 4'b1100, 4'b1010, 2'd2, 1'b0);
        tick();
        chk("bp first y", bus.y, 4'b0110);
        drive(1'b1, 4'b0001, 4'b0010, 2'd1, 1'b0);
        #1;
        chk("bp in_ready low", bus.in_ready, 0);
        tick();
        tick();
        chk("bp y held", bus.y, 4'b0110);
        chk("bp out_valid held", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp in_ready high", bus.in_ready, 1);
        tick();
        chk("bp second y", bus.y, 4'b0011);
        chk("bp second valid", bus.out_valid, 1);
        drive(1'b0, 4'b1111, 4'b1111, 2'd3, 1'b1);
        tick();
        chk("bp consumed", bus.out_valid, 0);
        chk("bp y after consume", bus.y, 4'b0011);
        chk("bp zero after consume", bus.zero, 0);

        // Reset wins over a pending result and an offered beat
        drive(1'b1, 4'b1111, 4'b1111, 2'd0, 1'b0);
        tick();
        chk("pre-rst y", bus.y, 4'b1111);
        rst = 1'b1;
        drive(1'b1, 4'b0001, 4'b0001, 2'd1, 1'b1);
        tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst y", bus.y, 0);
        chk("rst zero", bus.zero, 1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst beat dropped", bus.out_valid, 0);

`ifdef AND_IF_PARITY_EN
        drive(1'b1, 4'b0111, 4'b1111, 2'd0, 1'b1);
        tick();
        chk("parity y", bus.y, 4'b0111);
        chk("parity bit", bus.parity, 1);
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif

        last = 4'd0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd out_valid", bus.out_valid, q.size() != 0);
            chk("rnd y", bus.y, last);
            chk("rnd zero", bus.zero, last == 4'd0);
`ifdef AND_IF_PARITY_EN
            chk("rnd parity", bus.parity, ^last);
`endif
            rv  = 1'($urandom_range(0, 3) != 0);
            rr  = 1'($urandom_range(0, 2) != 0);
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rop = 2'($urandom);
            drive(rv, ra, rb, rop, rr);
            #1;
            exp_rdy = q.size() == 0 || rr;
            chk("rnd in_ready", bus.in_ready, exp_rdy);
            if (q.size() != 0 && rr) begin
                exp_y = q.pop_front();
                chk("rnd delivered", bus.y, exp_y);
            end
            if (rv && exp_rdy) begin
                last = ref_op(ra, rb, rop);
                q.push_back(last);
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/and_if.md
AND_IF -- requirements
Module: and_if

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits, legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block can accept an operand beat this cycle.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-009 out_valid  output  1  result register holds an undelivered result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 y  output  WIDTH  registered bitwise result.
REQ-012 zero  output  1  high when y equals all zeros.
REQ-013 parity  output  1  XOR-reduction of y; present only when AND_IF_PARITY_EN is defined.

Function
REQ-014 An input transfer occurs on a rising clk edge where in_valid and in_ready are both high; an output transfer occurs where out_valid and out_ready are both high.
REQ-015 On an input transfer, y loads op(a,b) bitwise per REQ-008, zero loads (op(a,b)==0), and out_valid sets; the result is visible exactly 1 cycle after the transfer edge.
REQ-016 in_ready is combinational: in_ready = !out_valid OR out_ready, giving single-entry, full-throughput buffering with no combinational path from a/b/op to y.
REQ-017 On an output transfer with no simultaneous input transfer, out_valid clears; y and zero hold their last values.
REQ-018 Simultaneous input and output transfers on the same edge: the old result is consumed and the new result loads; out_valid stays high.
REQ-019 While out_valid is high and out_ready is low, y, zero and out_valid hold stable, and in_ready is low.
REQ-020 a, b and op are sampled only on the edge of an input transfer; changes at any other time have no effect.
REQ-021 All outputs are driven from registers, except in_ready per REQ-016.

Reset
REQ-022 While rst is high at a clk edge: out_valid=0, y=0, zero=1, and parity=0 when present.
REQ-023 rst has priority over any simultaneous transfer; an input offered on a reset edge is dropped and an undelivered result is discarded.
REQ-024 in_ready is 1 from the first cycle after reset (out_valid=0).

Configuration
REQ-025 Macro AND_IF_PARITY_EN: when defined, port parity exists and is registered alongside y with parity = XOR-reduction of the loaded result; when undefined, the parity port and its logic are absent and all other behaviour is identical.

Verification
REQ-026 Reset, then a=1010, b=1111, op=00, in_valid=1, out_ready=1 for one edge -> next cycle y=1010 (10), zero=0, out_valid=1, parity=0 if enabled.
REQ-027 a=1010, b=0101, op=00 -> y=0000, zero=1; same operands with op=01 -> y=1111; op=10 -> y=1111; op=11 -> y=1111.
REQ-028 Load a result with out_ready=0, then offer a second beat -> in_ready=0, y holds the first result, and the second beat is not accepted until out_ready=1.
REQ-029 Continuous in_valid=1 and out_ready=1 with a new operand pair each cycle -> one result per cycle, each appearing 1 cycle after its input, with none lost or duplicated.
REQ-030 Assert rst while out_valid=1 and in_valid=1 -> next cycle out_valid=0, y=0000, zero=1, and the offered beat is dropped.
REQ-031 With AND_IF_PARITY_EN defined, a=0111, b=1111, op=00 -> y=0111, parity=1; with the macro undefined, the block elaborates with no parity port.
